codec_cfg_sequencer: RTL and testbench

- Sequences audio-codec register programming over a shared I2C write engine (24-bit word: device address, register, data).
- After reset, waits a power-up delay, then issues a fixed 9-entry init table with per-word NACK retry.
- After init completes, services runtime headphone-volume update requests as a left/right write pair.
- Sits between top-level control and the I2C serializer, and is the only master of that serializer.

---
 rtl/codec_cfg_sequencer.sv | 169 ++++++++++++++++
 tb/tb_codec_cfg_sequencer.sv | 276 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/codec_cfg_sequencer.sv
// Audio-codec configuration sequencer: after a power-up delay it writes a fixed
// init table, then runtime headphone-volume pairs, through a shared I2C write engine.
module codec_cfg_sequencer #(
    parameter logic [6:0] DEV_ADDR    = 7'h1A,
    parameter int         STARTUP_CYC = 1000,  // must be >= 1
    parameter int         GAP_CYC     = 16,    // must be >= 1
    parameter int         MAX_RETRY   = 3
) (
    input  logic        clk,
    input  logic        reset,
    output logic        i2c_start,
    output logic [23:0] i2c_word,
    input  logic        i2c_busy,
    input  logic        i2c_done,
    input  logic        i2c_nack,
    input  logic        vol_req,
    input  logic [6:0]  vol_val,
    output logic        vol_ack,
    output logic        init_done,
    output logic        init_err,
    output logic [3:0]  cur_index
);

    localparam int CNT_MAX = (STARTUP_CYC > GAP_CYC) ? STARTUP_CYC : GAP_CYC;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);
    localparam int RTY_W   = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;

    localparam logic [CNT_W-1:0] STARTUP_LAST = CNT_W'(STARTUP_CYC - 1);
    localparam logic [CNT_W-1:0] GAP_LAST     = CNT_W'(GAP_CYC - 1);
    localparam logic [RTY_W-1:0] RETRY_LIMIT  = RTY_W'(MAX_RETRY);

    localparam logic [3:0] LAST_INIT = 4'd8;
    localparam logic [3:0] VOL_LEFT  = 4'd9;
    localparam logic [3:0] VOL_RIGHT = 4'd10;

    typedef enum logic [2:0] {
        ST_STARTUP,
        ST_ISSUE,
        ST_WAIT,
        ST_GAP,
        ST_RUN,
        ST_FAIL
    } state_t;

    state_t           state;
    logic [CNT_W-1:0] cnt;
    logic [RTY_W-1:0] retry_cnt;
    logic [6:0]       vol_lat;
    logic [6:0]       word_reg;
    logic [8:0]       word_data;

    // Register/data pair for the word selected by cur_index.
    // NOTE: defaults first so every path assigns both outputs and no latch is inferred.
    always_comb begin
        word_reg  = 7'd0;
        word_data = 9'h000;
        case (cur_index)
            4'd0:      begin word_reg = 7'd15; word_data = 9'h000; end
            4'd1:      begin word_reg = 7'd6;  word_data = 9'h000; end
            4'd2:      begin word_reg = 7'd4;  word_data = 9'h015; end
            4'd3:      begin word_reg = 7'd8;  word_data = 9'h00C; end
            4'd4:      begin word_reg = 7'd7;  word_data = 9'h052; end
            4'd5:      begin word_reg = 7'd2;  word_data = 9'h079; end
            4'd6:      begin word_reg = 7'd3;  word_data = 9'h079; end
            4'd7:      begin word_reg = 7'd5;  word_data = 9'h000; end
            4'd8:      begin word_reg = 7'd9;  word_data = 9'h001; end
            VOL_LEFT:  begin word_reg = 7'd2;  word_data = {2'b00, vol_lat}; end
            VOL_RIGHT: begin word_reg = 7'd3;  word_data = {2'b00, vol_lat}; end
            default:   begin word_reg = 7'd0;  word_data = 9'h000; end
        endcase
    end

    // NOTE: all state uses non-blocking assignments so every register sees pre-edge values.
    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= ST_STARTUP;
            cnt       <= '0;
            retry_cnt <= '0;
            vol_lat   <= '0;
            i2c_start <= 1'b0;
            i2c_word  <= '0;
            vol_ack   <= 1'b0;
            init_done <= 1'b0;
            init_err  <= 1'b0;
            cur_index <= '0;
        end else begin
            i2c_start <= 1'b0;
            vol_ack   <= 1'b0;

            case (state)
                ST_STARTUP: begin
                    if (cnt == STARTUP_LAST) begin
                        cnt   <= '0;
                        state <= ST_ISSUE;
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end

                ST_ISSUE: begin
                    if (!i2c_busy) begin
                        i2c_start <= 1'b1;
                        i2c_word  <= {DEV_ADDR, 1'b0, word_reg, word_data};
                        state     <= ST_WAIT;
                    end
                end

                // Only a done seen here belongs to our own transfer.
                ST_WAIT: begin
                    if (i2c_done) begin
                        if (!i2c_nack) begin
                            retry_cnt <= '0;
                            cnt       <= '0;
                            state     <= ST_GAP;
                        end else if (retry_cnt < RETRY_LIMIT) begin
                            retry_cnt <= retry_cnt + RTY_W'(1);
                            cnt       <= '0;
                            state     <= ST_GAP;
                        end else begin
                            init_err <= 1'b1;
                            state    <= ST_FAIL;
                        end
                    end
                end

                // A non-zero retry count means the last word was NACKed and is re-sent.
                ST_GAP: begin
                    if (cnt == GAP_LAST) begin
                        cnt <= '0;
                        if (retry_cnt != '0) begin
                            state <= ST_ISSUE;
                        end else if (cur_index < LAST_INIT) begin
                            cur_index <= cur_index + 4'd1;
                            state     <= ST_ISSUE;
                        end else if (cur_index == LAST_INIT) begin
                            init_done <= 1'b1;
                            state     <= ST_RUN;
                        end else if (cur_index == VOL_LEFT) begin
                            cur_index <= VOL_RIGHT;
                            state     <= ST_ISSUE;
                        end else begin
                            vol_ack <= 1'b1;
                            state   <= ST_RUN;
                        end
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end

                ST_RUN: begin
                    if (vol_req) begin
                        vol_lat   <= vol_val;
                        cur_index <= VOL_LEFT;
                        state     <= ST_ISSUE;
                    end
                end

                ST_FAIL: begin
                    state <= ST_FAIL;
                end

                default: begin
                    state <= ST_STARTUP;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_codec_cfg_sequencer.sv
// Directed bench for codec_cfg_sequencer with a behavioural I2C serializer that
// takes 20 cycles per transfer and NACKs according to a per-index table.
module tb_codec_cfg_sequencer;

    localparam int STARTUP_CYC = 10;
    localparam int GAP_CYC     = 4;
    localparam int MAX_RETRY   = 3;
    localparam int XFER_CYC    = 20;

    logic        clk = 1'b0;
    logic        reset;
    logic        i2c_start;
    logic [23:0] i2c_word;
    logic        i2c_busy;
    logic        i2c_done;
    logic        i2c_nack;
    logic        vol_req;
    logic [6:0]  vol_val;
    logic        vol_ack;
    logic        init_done;
    logic        init_err;
    logic [3:0]  cur_index;

    logic model_busy;
    logic hold_busy;
    assign i2c_busy = model_busy | hold_busy;

    int vectors     = 0;
    int miscompares = 0;
    int cyc         = 0;
    int done_cyc    = 0;
    int ack_cnt     = 0;
    int ack_cyc     = 0;
    int nack_left[11];

    logic [23:0] word_q[$];
    logic [3:0]  idx_q[$];

    codec_cfg_sequencer #(
        .DEV_ADDR   (7'h1A),
        .STARTUP_CYC(STARTUP_CYC),
        .GAP_CYC    (GAP_CYC),
        .MAX_RETRY  (MAX_RETRY)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .i2c_start(i2c_start),
        .i2c_word (i2c_word),
        .i2c_busy (i2c_busy),
        .i2c_done (i2c_done),
        .i2c_nack (i2c_nack),
        .vol_req  (vol_req),
        .vol_val  (vol_val),
        .vol_ack  (vol_ack),
        .init_done(init_done),
        .init_err (init_err),
        .cur_index(cur_index)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (vol_ack === 1'b1) begin
            ack_cnt = ack_cnt + 1;
            ack_cyc = cyc;
        end
    end

    // Serializer model: accepts a start, stays busy XFER_CYC cycles, then pulses done.
    initial begin
        int xfer_left;
        int xfer_idx;
        xfer_left  = 0;
        xfer_idx   = 0;
        model_busy = 1'b0;
        i2c_done   = 1'b0;
        i2c_nack   = 1'b0;
        forever begin
            @(negedge clk);
            i2c_done = 1'b0;
            i2c_nack = 1'b0;
            if (reset) begin
                model_busy = 1'b0;
                xfer_left  = 0;
            end else if (xfer_left > 0) begin
                xfer_left = xfer_left - 1;
                if (xfer_left == 0) begin
                    i2c_done   = 1'b1;
                    model_busy = 1'b0;
                    done_cyc   = cyc;
                    if (nack_left[xfer_idx] > 0) begin
                        i2c_nack            = 1'b1;
                        nack_left[xfer_idx] = nack_left[xfer_idx] - 1;
                    end
                end
            end else if (i2c_start === 1'b1) begin
                model_busy = 1'b1;
                xfer_left  = XFER_CYC;
                xfer_idx   = (cur_index <= 4'd10) ? int'(cur_index) : 0;
                word_q.push_back(i2c_word);
                idx_q.push_back(cur_index);
            end
        end
    end

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [23:0] logged_word(input int i);
        logged_word = (i < word_q.size()) ? word_q[i] : 24'hxxxxxx;
    endfunction

    task automatic clear_log();
        word_q.delete();
        idx_q.delete();
        ack_cnt = 0;
    endtask

    // Called just after a negedge; leaves with reset released on a negedge.
    task automatic do_reset(input string tag);
        reset = 1'b1;
        repeat (3) @(negedge clk);
        check({tag, "_rst_start"},     i2c_start, 0);
        check({tag, "_rst_word"},      i2c_word,  0);
        check({tag, "_rst_vol_ack"},   vol_ack,   0);
        check({tag, "_rst_init_done"}, init_done, 0);
        check({tag, "_rst_init_err"},  init_err,  0);
        check({tag, "_rst_cur_index"}, cur_index, 0);
        for (int i = 0; i < 11; i++) nack_left[i] = 0;
        clear_log();
        reset = 1'b0;
    endtask

    task automatic wait_first_start(input string tag);
        int n;
        n = 0;
        while (i2c_start !== 1'b1 && n < 200) begin
            @(negedge clk);
            n++;
        end
        check({tag, "_first_start_latency"}, n, STARTUP_CYC + 1);
    endtask

    task automatic wait_init(input string tag, output int end_cyc);
        int n;
        n = 0;
        while (!(init_done === 1'b1 || init_err === 1'b1) && n < 3000) begin
            @(negedge clk);
            n++;
        end
        end_cyc = cyc;
        check({tag, "_init_finished_in_time"}, (n < 3000) ? 1 : 0, 1);
    endtask

    logic [23:0] init_words[9];
    int end_cyc;
    int starts;

    initial begin
        init_words[0] = 24'h341E00;
        init_words[1] = 24'h340C00;
        init_words[2] = 24'h340815;
        init_words[3] = 24'h34100C;
        init_words[4] = 24'h340E52;
        init_words[5] = 24'h340479;
        init_words[6] = 24'h340679;
        init_words[7] = 24'h340A00;
        init_words[8] = 24'h341201;

        reset     = 1'b1;
        vol_req   = 1'b0;
        vol_val   = 7'h00;
        hold_busy = 1'b0;
        for (int i = 0; i < 11; i++) nack_left[i] = 0;

        // Clean init: nine ACKed words in table order.
        @(negedge clk);
        do_reset("t1");
        wait_first_start("t1");
        wait_init("t1", end_cyc);
        check("t1_start_count", word_q.size(), 9);
        for (int i = 0; i < 9; i++) begin
            check($sformatf("t1_word%0d", i), logged_word(i), init_words[i]);
            check($sformatf("t1_idx%0d", i), (i < idx_q.size()) ? idx_q[i] : 4'hx, i);
        end
        check("t1_init_done", init_done, 1);
        check("t1_init_err", init_err, 0);
        check("t1_done_after_gap", end_cyc - done_cyc, GAP_CYC + 1);

        // Index 3 NACKed twice, then ACKed.
        do_reset("t2");
        nack_left[3] = 2;
        wait_init("t2", end_cyc);
        check("t2_start_count", word_q.size(), 11);
        check("t2_word3_try0", logged_word(3), 24'h34100C);
        check("t2_word3_try1", logged_word(4), 24'h34100C);
        check("t2_word3_try2", logged_word(5), 24'h34100C);
        check("t2_word4_after_retry", logged_word(6), 24'h340E52);
        check("t2_last_word", logged_word(10), 24'h341201);
        check("t2_init_done", init_done, 1);
        check("t2_init_err", init_err, 0);

        // Volume update; vol_val changes after acceptance and must not leak through.
        repeat (5) @(negedge clk);
        clear_log();
        vol_req = 1'b1;
        vol_val = 7'h50;
        @(negedge clk);
        vol_req = 1'b0;
        vol_val = 7'h11;
        repeat (200) @(negedge clk);
        check("t3_start_count", word_q.size(), 2);
        check("t3_left_word", logged_word(0), 24'h340450);
        check("t3_right_word", logged_word(1), 24'h340650);
        check("t3_vol_ack_count", ack_cnt, 1);
        check("t3_ack_after_gap", ack_cyc - done_cyc, GAP_CYC + 1);
        check("t3_init_done_kept", init_done, 1);

        // Index 4 always NACKed: 1 + MAX_RETRY issues, then terminal failure.
        do_reset("t4");
        nack_left[4] = 1000;
        wait_init("t4", end_cyc);
        check("t4_start_count", word_q.size(), 4 + 1 + MAX_RETRY);
        for (int i = 4; i < 8; i++)
            check($sformatf("t4_word4_try%0d", i - 4), logged_word(i), 24'h340E52);
        check("t4_init_err", init_err, 1);
        check("t4_init_done", init_done, 0);
        clear_log();
        vol_req = 1'b1;
        vol_val = 7'h22;
        repeat (1000) @(negedge clk);
        vol_req = 1'b0;
        check("t4_no_start_in_fail", word_q.size(), 0);
        check("t4_no_vol_ack_in_fail", ack_cnt, 0);
        check("t4_init_err_sticky", init_err, 1);

        // Busy held across ISSUE, then reset while a transfer is pending.
        hold_busy = 1'b1;
        do_reset("t5");
        starts = 0;
        repeat (STARTUP_CYC + 50) begin
            @(negedge clk);
            if (i2c_start === 1'b1) starts++;
        end
        check("t5_no_start_while_busy", starts, 0);
        hold_busy = 1'b0;
        @(negedge clk);
        check("t5_start_after_busy_drop", i2c_start, 1);
        check("t5_start_word", i2c_word, 24'h341E00);
        @(negedge clk);
        check("t5_start_one_cycle", i2c_start, 0);
        repeat (5) @(negedge clk);
        do_reset("t5b");
        wait_first_start("t5b");
        check("t5b_restart_word", i2c_word, 24'h341E00);
        check("t5b_restart_index", cur_index, 0);
        repeat (40) @(negedge clk);
        check("t5b_second_word", logged_word(1), 24'h340C00);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
